udp_tx_sched: RTL and testbench

//  Round-robin scheduler sharing the single ros2_ether UDP TX buffer port among
//  NUM_CLI independent senders (each sender owns a read-only 32-bit frame buffer:

---
 rtl/udp_tx_sched.sv | 171 +++++++++++++++++
 tb/tb_udp_tx_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_sched.sv
// udp_tx_sched
// Round-robin scheduler that shares the single ros2_ether UDP TX buffer port
// among NUM_CLI senders. A pending sender is picked while the application side
// holds the buffer. Ownership is handed to ros2_ether with a one-cycle release
// pulse. While the transfer runs, buffer reads are routed to the owning sender.
// Each frame ends with a done pulse when the buffer comes back, or with an err
// pulse on timeout.
//
// Ports
//   clk_int, rst_n       clock, asynchronous active-low reset
//   cli_req              level request per sender, held until done/err
//   cli_busy             one-hot owner of the port (REL/TAKE/DONE)
//   cli_done, cli_err    one-cycle completion / timeout pulses per sender
//   cli_addr, cli_ce     buffer read address (broadcast) and per-sender enable
//   cli_rdata            per-sender read data, slice i = [32*i+31:32*i]
//   owner_id             index of current/last owner
//   udp_txbuf_grant      1 = buffer held by application side
//   udp_txbuf_rel        one-cycle pulse handing the buffer to ros2_ether
//   udp_txbuf_addr/ce    read request from ros2_ether
//   udp_txbuf_rdata      read data to ros2_ether (0 when no owner)
module udp_tx_sched #(
  parameter int unsigned NUM_CLI        = 4,
  parameter int unsigned AWIDTH         = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1250000
) (
  input  logic                  clk_int,
  input  logic                  rst_n,
  input  logic [NUM_CLI-1:0]    cli_req,
  output logic [NUM_CLI-1:0]    cli_busy,
  output logic [NUM_CLI-1:0]    cli_done,
  output logic [NUM_CLI-1:0]    cli_err,
  output logic [AWIDTH-1:0]     cli_addr,
  output logic [NUM_CLI-1:0]    cli_ce,
  input  logic [NUM_CLI*32-1:0] cli_rdata,
  output logic [2:0]            owner_id,
  input  logic                  udp_txbuf_grant,
  output logic                  udp_txbuf_rel,
  input  logic [AWIDTH-1:0]     udp_txbuf_addr,
  input  logic                  udp_txbuf_ce,
  output logic [31:0]           udp_txbuf_rdata
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TimerLimit = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StRel, StTake, StDone} state_e;

  state_e               state_q;
  logic [2:0]           rr_q;
  logic [2:0]           owner_q;
  logic [NUM_CLI-1:0]   busy_q;
  logic [NUM_CLI-1:0]   done_q;
  logic [NUM_CLI-1:0]   err_q;
  logic                 rel_q;
  logic [TW-1:0]        timer_q;

  logic [7:0]           req_pad;
  logic [2:0]           cand;
  logic                 sel_valid;
  logic [2:0]           sel_idx;
  logic [NUM_CLI-1:0]   sel_onehot;
  logic [NUM_CLI-1:0]   owner_onehot;
  logic [2:0]           next_ptr;
  logic [TW-1:0]        timer_inc;
  logic                 timeout_hit;
  logic [31:0]          rdata_mux;

  assign req_pad = 8'(cli_req);

  // First requester at or after the round-robin pointer, wrapping at NUM_CLI.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_CLI; i++) begin
      cand = 3'((32'(rr_q) + i) % NUM_CLI);
      if (!sel_valid && req_pad[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign sel_onehot   = NUM_CLI'(1) << sel_idx;
  assign owner_onehot = NUM_CLI'(1) << owner_q;
  assign next_ptr     = (32'(owner_q) == NUM_CLI - 1) ? 3'd0 : owner_q + 3'd1;

  // timer_q counts completed TAKE/DONE cycles since REL; the err pulse therefore
  // lands TIMEOUT_CYCLES cycles after the REL cycle.
  assign timer_inc   = timer_q + TW'(1);
  assign timeout_hit = (timer_inc >= TimerLimit);

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rr_q    <= '0;
      owner_q <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rel_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      rel_q  <= 1'b0;
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        StIdle: begin
          if (udp_txbuf_grant && sel_valid) begin
            owner_q <= sel_idx;
            busy_q  <= sel_onehot;
            rel_q   <= 1'b1;
            state_q <= StRel;
          end
        end
        StRel: begin
          timer_q <= '0;
          state_q <= StTake;
        end
        StTake: begin
          // Leaving TAKE takes priority over a coincident timeout.
          if (!udp_txbuf_grant) begin
            timer_q <= timer_inc;
            state_q <= StDone;
          end else if (timeout_hit) begin
            err_q   <= owner_onehot;
            busy_q  <= '0;
            rr_q    <= next_ptr;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_inc;
          end
        end
        StDone: begin
          if (udp_txbuf_grant) begin
            done_q  <= owner_onehot;
            busy_q  <= '0;
            rr_q    <= next_ptr;
            state_q <= StIdle;
          end else if (timeout_hit) begin
            err_q   <= owner_onehot;
            busy_q  <= '0;
            rr_q    <= next_ptr;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_inc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read mux keyed on busy so that no owner means zero data.
  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < int'(NUM_CLI); i++) begin
      if (busy_q[i]) rdata_mux = cli_rdata[32*i +: 32];
    end
  end

  assign cli_busy        = busy_q;
  assign cli_done        = done_q;
  assign cli_err         = err_q;
  assign owner_id        = owner_q;
  assign udp_txbuf_rel   = rel_q;
  assign cli_addr        = udp_txbuf_addr;
  assign cli_ce          = {NUM_CLI{udp_txbuf_ce}} & busy_q;
  assign udp_txbuf_rdata = rdata_mux;

endmodule

// File: tb/tb_udp_tx_sched.sv
module tb_udp_tx_sched;

  logic         clk_int = 1'b0;
  logic         rst_n;
  logic [3:0]   cli_req;
  logic [3:0]   cli_busy;
  logic [3:0]   cli_done;
  logic [3:0]   cli_err;
  logic [5:0]   cli_addr;
  logic [3:0]   cli_ce;
  logic [127:0] cli_rdata;
  logic [2:0]   owner_id;
  logic         udp_txbuf_grant;
  logic         udp_txbuf_rel;
  logic [5:0]   udp_txbuf_addr;
  logic         udp_txbuf_ce;
  logic [31:0]  udp_txbuf_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  udp_tx_sched #(
    .NUM_CLI       (4),
    .AWIDTH        (6),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_int        (clk_int),
    .rst_n          (rst_n),
    .cli_req        (cli_req),
    .cli_busy       (cli_busy),
    .cli_done       (cli_done),
    .cli_err        (cli_err),
    .cli_addr       (cli_addr),
    .cli_ce         (cli_ce),
    .cli_rdata      (cli_rdata),
    .owner_id       (owner_id),
    .udp_txbuf_grant(udp_txbuf_grant),
    .udp_txbuf_rel  (udp_txbuf_rel),
    .udp_txbuf_addr (udp_txbuf_addr),
    .udp_txbuf_ce   (udp_txbuf_ce),
    .udp_txbuf_rdata(udp_txbuf_rdata)
  );

  always #5 clk_int = ~clk_int;

  task automatic tick;
    @(posedge clk_int);
    #1;
  endtask

  task automatic test_reset;
    rst_n           = 1'b0;
    cli_req         = 4'b0000;
    udp_txbuf_grant = 1'b1;
    udp_txbuf_addr  = 6'h00;
    udp_txbuf_ce    = 1'b1;
    cli_rdata       = {32'hdead0003, 32'hdead0002, 32'h0a01a8c0, 32'hdead0000};
    #12;
    n_cmp++; if (cli_busy !== 4'b0000) begin n_bad++; $display("FAIL reset_busy got %b want 0000", cli_busy); end
    n_cmp++; if (udp_txbuf_rel !== 1'b0) begin n_bad++; $display("FAIL reset_rel got %b want 0", udp_txbuf_rel); end
    n_cmp++; if (owner_id !== 3'd0) begin n_bad++; $display("FAIL reset_owner got %0d want 0", owner_id); end
    n_cmp++; if ({cli_done, cli_err} !== 8'h00) begin n_bad++; $display("FAIL reset_done_err got %b want 0", {cli_done, cli_err}); end
    n_cmp++; if (cli_ce !== 4'b0000) begin n_bad++; $display("FAIL reset_ce got %b want 0000", cli_ce); end
    n_cmp++; if (udp_txbuf_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", udp_txbuf_rdata); end
    udp_txbuf_ce = 1'b0;
    @(negedge clk_int);
    rst_n = 1'b1;
  endtask

  // T1: sender 2 alone, full handshake.
  task automatic test_single;
    cli_req = 4'b0100;
    tick;
    n_cmp++; if (udp_txbuf_rel !== 1'b1) begin n_bad++; $display("FAIL single_rel got %b want 1", udp_txbuf_rel); end
    n_cmp++; if (cli_busy !== 4'b0100) begin n_bad++; $display("FAIL single_busy got %b want 0100", cli_busy); end
    n_cmp++; if (owner_id !== 3'd2) begin n_bad++; $display("FAIL single_owner got %0d want 2", owner_id); end
    tick;
    n_cmp++; if (udp_txbuf_rel !== 1'b0) begin n_bad++; $display("FAIL single_rel_width got %b want 0", udp_txbuf_rel); end
    udp_txbuf_grant = 1'b0;
    tick;
    tick;
    n_cmp++; if (cli_done !== 4'b0000) begin n_bad++; $display("FAIL single_early_done got %b want 0000", cli_done); end
    udp_txbuf_grant = 1'b1;
    tick;
    n_cmp++; if (cli_done !== 4'b0100) begin n_bad++; $display("FAIL single_done got %b want 0100", cli_done); end
    n_cmp++; if (cli_busy !== 4'b0000) begin n_bad++; $display("FAIL single_busy_end got %b want 0000", cli_busy); end
    cli_req = 4'b0000;
    tick;
    n_cmp++; if (cli_done !== 4'b0000) begin n_bad++; $display("FAIL single_done_width got %b want 0000", cli_done); end
  endtask

  // T2: all four requesting from pointer 0 -> owners 0,1,2,3,0.
  task automatic test_round_robin;
    int rels;
    bit seen;
    logic [2:0] exp_owner;
    logic [3:0] exp_oh;
    @(negedge clk_int);
    rst_n = 1'b0;
    @(negedge clk_int);
    rst_n = 1'b1;
    cli_req = 4'b1111;
    udp_txbuf_grant = 1'b1;
    for (int f = 0; f < 5; f++) begin
      exp_owner = 3'(f % 4);
      exp_oh    = 4'b0001 << exp_owner;
      rels = 0;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        tick;
        if (udp_txbuf_rel) begin rels++; seen = 1'b1; end
      end
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL rr_rel_wait frame %0d got no rel want rel", f); end
      n_cmp++; if (owner_id !== exp_owner) begin n_bad++; $display("FAIL rr_owner frame %0d got %0d want %0d", f, owner_id, exp_owner); end
      udp_txbuf_grant = 1'b0;
      tick; if (udp_txbuf_rel) rels++;
      tick; if (udp_txbuf_rel) rels++;
      udp_txbuf_grant = 1'b1;
      tick; if (udp_txbuf_rel) rels++;
      n_cmp++; if (cli_done !== exp_oh) begin n_bad++; $display("FAIL rr_done frame %0d got %b want %b", f, cli_done, exp_oh); end
      n_cmp++; if (rels != 1) begin n_bad++; $display("FAIL rr_rel_count frame %0d got %0d want 1", f, rels); end
    end
    cli_req = 4'b0000;
    tick;
  endtask

  // T3: owner 1 serves reads; pointer is 1 after T2.
  task automatic test_readback;
    cli_req = 4'b0010;
    tick;
    n_cmp++; if (owner_id !== 3'd1) begin n_bad++; $display("FAIL rb_owner got %0d want 1", owner_id); end
    udp_txbuf_ce   = 1'b1;
    udp_txbuf_addr = 6'h00;
    #1;
    n_cmp++; if (udp_txbuf_rdata !== 32'h0a01a8c0) begin n_bad++; $display("FAIL rb_rdata got %h want 0a01a8c0", udp_txbuf_rdata); end
    n_cmp++; if (cli_ce !== 4'b0010) begin n_bad++; $display("FAIL rb_ce got %b want 0010", cli_ce); end
    udp_txbuf_addr = 6'h2a;
    #1;
    n_cmp++; if (cli_addr !== 6'h2a) begin n_bad++; $display("FAIL rb_addr got %h want 2a", cli_addr); end
    udp_txbuf_ce = 1'b0;
    #1;
    n_cmp++; if (cli_ce !== 4'b0000) begin n_bad++; $display("FAIL rb_ce_off got %b want 0000", cli_ce); end
    udp_txbuf_grant = 1'b0;
    tick;
    tick;
    udp_txbuf_grant = 1'b1;
    tick;
    n_cmp++; if (cli_done !== 4'b0010) begin n_bad++; $display("FAIL rb_done got %b want 0010", cli_done); end
    cli_req = 4'b0000;
    udp_txbuf_ce = 1'b1;
    #1;
    n_cmp++; if ({cli_ce, udp_txbuf_rdata} !== 36'h0) begin n_bad++; $display("FAIL rb_idle_path got %b/%h want 0/0", cli_ce, udp_txbuf_rdata); end
    udp_txbuf_ce = 1'b0;
    tick;
  endtask

  // T4: grant never drops after REL (pointer 2) -> err 100 cycles after REL cycle.
  task automatic test_timeout;
    bit early;
    cli_req = 4'b0100;
    tick;
    n_cmp++; if (udp_txbuf_rel !== 1'b1 || owner_id !== 3'd2) begin n_bad++; $display("FAIL to_rel got rel=%b owner=%0d want 1/2", udp_txbuf_rel, owner_id); end
    udp_txbuf_grant = 1'b0;
    early = 1'b0;
    for (int k = 1; k < 100; k++) begin
      tick;
      if (cli_err !== 4'b0000 || cli_busy !== 4'b0100 || cli_done !== 4'b0000) early = 1'b1;
    end
    n_cmp++; if (early) begin n_bad++; $display("FAIL to_early got early err/busy change want none before cycle 100"); end
    tick;
    n_cmp++; if (cli_err !== 4'b0100) begin n_bad++; $display("FAIL to_err got %b want 0100", cli_err); end
    n_cmp++; if (cli_done !== 4'b0000 || cli_busy !== 4'b0000) begin n_bad++; $display("FAIL to_done_busy got %b/%b want 0000/0000", cli_done, cli_busy); end
    cli_req = 4'b0000;
    tick;
    n_cmp++; if (cli_err !== 4'b0000) begin n_bad++; $display("FAIL to_err_width got %b want 0000", cli_err); end
    // Pointer must have moved to 3: with 2 and 3 both requesting, 3 wins.
    cli_req = 4'b1100;
    udp_txbuf_grant = 1'b1;
    tick;
    n_cmp++; if (owner_id !== 3'd3) begin n_bad++; $display("FAIL to_ptr got %0d want 3", owner_id); end
    cli_req = 4'b1000;
    udp_txbuf_grant = 1'b0;
    tick;
    tick;
    udp_txbuf_grant = 1'b1;
    tick;
    n_cmp++; if (cli_done !== 4'b1000) begin n_bad++; $display("FAIL to_next_done got %b want 1000", cli_done); end
    cli_req = 4'b0000;
    tick;
  endtask

  // T5: no release while grant is low.
  task automatic test_grant_gating;
    int rels;
    int busy_seen;
    udp_txbuf_grant = 1'b0;
    cli_req = 4'b0001;
    rels = 0;
    busy_seen = 0;
    for (int c = 0; c < 50; c++) begin
      tick;
      if (udp_txbuf_rel) rels++;
      if (cli_busy != 4'b0000) busy_seen++;
    end
    n_cmp++; if (rels != 0 || busy_seen != 0) begin n_bad++; $display("FAIL gate_hold got rel=%0d busy=%0d want 0/0", rels, busy_seen); end
    udp_txbuf_grant = 1'b1;
    tick;
    n_cmp++; if (udp_txbuf_rel !== 1'b1 || owner_id !== 3'd0) begin n_bad++; $display("FAIL gate_rel got rel=%b owner=%0d want 1/0", udp_txbuf_rel, owner_id); end
    udp_txbuf_grant = 1'b0;
    tick;
    tick;
    udp_txbuf_grant = 1'b1;
    tick;
    n_cmp++; if (cli_done !== 4'b0001) begin n_bad++; $display("FAIL gate_done got %b want 0001", cli_done); end
    cli_req = 4'b0000;
    tick;
  endtask

  // T6: reset during TAKE (owner 1, pointer 1) -> async clear, then sender 0 first.
  task automatic test_reset_mid;
    cli_req = 4'b0010;
    udp_txbuf_grant = 1'b1;
    tick;
    tick;
    n_cmp++; if (cli_busy !== 4'b0010) begin n_bad++; $display("FAIL rm_busy_take got %b want 0010", cli_busy); end
    udp_txbuf_ce = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cli_busy !== 4'b0000 || udp_txbuf_rel !== 1'b0) begin n_bad++; $display("FAIL rm_async got busy=%b rel=%b want 0000/0", cli_busy, udp_txbuf_rel); end
    n_cmp++; if (cli_ce !== 4'b0000 || udp_txbuf_rdata !== 32'h0 || owner_id !== 3'd0) begin n_bad++; $display("FAIL rm_path got ce=%b rdata=%h owner=%0d want 0/0/0", cli_ce, udp_txbuf_rdata, owner_id); end
    udp_txbuf_ce = 1'b0;
    cli_req = 4'b0011;
    #2;
    rst_n = 1'b1;
    tick;
    n_cmp++; if (udp_txbuf_rel !== 1'b1 || owner_id !== 3'd0 || cli_busy !== 4'b0001) begin n_bad++; $display("FAIL rm_first got rel=%b owner=%0d busy=%b want 1/0/0001", udp_txbuf_rel, owner_id, cli_busy); end
    cli_req = 4'b0000;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_readback;
    test_timeout;
    test_grant_gating;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
